wb_bus_arbiter: RTL
===================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the slave-silence cycles before a granted cycle is force-terminated; legal range 1..65535.
REQ-002 Parameter TIMEOUT_DATA, default 32'h0000_0000, is the read data returned on a timed-out cycle.
REQ-003 wb_clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 Instruction-master port: wb_ibus_adr_i in 32, wb_ibus_cyc_i in 1, wb_ibus_dat_o out 32, wb_ibus_ack_o out 1; read-only; cyc doubles as stb.
REQ-006 Data-master port: wb_dbus_adr_i in 32, wb_dbus_dat_i in 32, wb_dbus_we_i in 1, wb_dbus_sel_i in 4, wb_dbus_stb_i in 1, wb_dbus_cyc_i in 1, wb_dbus_dat_o out 32, wb_dbus_ack_o out 1.
REQ-007 Shared slave port: wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_cyc_o out 1, wb_ack_i in 1.
REQ-008 timeout_o  out  1  one-cycle pulse on each forced termination.

Function
REQ-009 FSM states: IDLE, GNT_I, GNT_D; state and a last_grant bit are registered.
REQ-010 In IDLE, a request is wb_ibus_cyc_i for the instruction master and (wb_dbus_cyc_i & wb_dbus_stb_i) for the data master.
REQ-011 IDLE with a single request: the requesting master is granted and the FSM enters its GNT state on the next edge; the grant latency is one cycle.
REQ-012 IDLE with both requests: the master not named by last_grant is granted, giving round-robin between the two masters.
REQ-013 On entering a GNT state, last_grant is updated to that master.
REQ-014 In GNT_I, the slave port carries adr=wb_ibus_adr_i, we=0, sel=4'hF, dat_o=0, and stb=cyc=wb_ibus_cyc_i.
REQ-015 In GNT_D, the slave port carries the data-master signals unmodified.
REQ-016 wb_dat_i is routed to both masters' dat_o at all times.
REQ-017 wb_ack_i is gated to the granted master's ack output only, combinationally, with zero added latency.
REQ-018 In IDLE, all slave-port controls (cyc, stb, we, sel) are 0, adr and dat_o are 0, and both master acks are 0.
REQ-019 Granted-master ack, or granted master dropping cyc (abort): the FSM returns to IDLE on that edge.
REQ-020 Following REQ-019, the next grant is decided in IDLE the following cycle, so back-to-back cycles from the same master see one idle cycle.
REQ-021 A timeout counter is cleared on grant and increments each GNT cycle without wb_ack_i.
REQ-022 When the timeout counter equals TIMEOUT_CYCLES, the arbiter, in that same cycle:
  - asserts the granted master's ack,
  - drives that master's dat_o with TIMEOUT_DATA,
  - pulses timeout_o,
  - deasserts slave cyc/stb,
  - returns to IDLE.
REQ-023 If wb_ack_i and the timeout coincide, the ack wins: the slave data is returned and timeout_o stays 0.
REQ-024 The non-granted master's request is held off (ack=0) without limit until it is granted; requests are never dropped.

Reset
REQ-025 Asserting wb_rst_ni low, including mid-transaction, forces state=IDLE, last_grant=dbus (so ibus wins the first contention), timeout counter=0, timeout_o=0, and all outputs to the IDLE values of REQ-018, asynchronously.
REQ-026 After reset release, the first grant is possible on the first rising edge.

Structure
REQ-027 The FSM state encoding and grant-id constants reside in a shared package, atom_wb_pkg, reused by future interconnect blocks.
REQ-028 The timeout counter is a sub-module, wb_timeout_ctr, with a clear input, an enable input and an expire output; its width is $clog2(TIMEOUT_CYCLES+1).
REQ-029 The block sits between the CPU Wishbone wrapper's two master ports and a single shared memory/peripheral bus.

Verification
REQ-030 Single ibus read:
  - stimulus: ibus cyc, adr=0x100; slave acks 2 cycles after stb with 0x13.
  - response: wb_cyc_o rises 1 cycle after request; wb_ibus_ack_o rises with the slave ack; wb_ibus_dat_o=0x13; returns to IDLE.
REQ-031 Simultaneous requests from reset:
  - stimulus: ibus and dbus both request in the first cycle after reset.
  - response: ibus is granted first; dbus is granted in the IDLE cycle after the ibus ack.
  - stimulus: both request again.
  - response: the grant goes to ibus, since last_grant=dbus.
REQ-032 dbus byte write:
  - stimulus: we=1, sel=4'b0100, adr=0x2002, dat=0x00AB0000.
  - response: the slave port shows identical values; wb_dbus_ack_o mirrors wb_ack_i.
REQ-033 Timeout:
  - stimulus: TIMEOUT_CYCLES=4, slave never acks a dbus read.
  - response: on the 5th GNT cycle (counter=4), wb_dbus_ack_o=1, dat=TIMEOUT_DATA, timeout_o pulses, and wb_cyc_o drops.
  - stimulus: slave ack in the same cycle as the timeout.
  - response: slave data is returned and timeout_o=0.
REQ-034 Abort and reset:
  - stimulus: dbus drops cyc mid-wait.
  - response: the FSM returns to IDLE; there is no spurious ack.
  - stimulus: wb_rst_ni is pulsed low mid-grant.
  - response: wb_cyc_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/atom_wb_pkg.sv
// Shared Wishbone interconnect definitions: arbiter state encoding, grant ids
// and the two-master round-robin pick used when deciding a grant from IDLE.
package atom_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // On contention the master that did not win last time is chosen.
    function automatic arb_state_e rr_pick(input logic req_i, input logic req_d,
                                           input logic last_grant);
        arb_state_e pick;
        if (req_i && req_d) begin
            if (last_grant == GRANT_D) begin
                pick = ST_GNT_I;
            end else begin
                pick = ST_GNT_D;
            end
        end else if (req_i) begin
            pick = ST_GNT_I;
        end else if (req_d) begin
            pick = ST_GNT_D;
        end else begin
            pick = ST_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Slave-silence counter: cleared while clr_i is high, counts enabled cycles
// and flags expiry once the count reaches MAX_COUNT.
module wb_timeout_ctr #(
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(MAX_COUNT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = (cnt_q == W'(MAX_COUNT));

    // Next count; holds at MAX_COUNT so it can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with
// round-robin grant, zero-latency ack routing and a slave-silence timeout.
module wb_bus_arbiter
    import atom_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_ibus_adr_i,
    input  logic        wb_ibus_cyc_i,
    output logic [31:0] wb_ibus_dat_o,
    output logic        wb_ibus_ack_o,
    input  logic [31:0] wb_dbus_adr_i,
    input  logic [31:0] wb_dbus_dat_i,
    input  logic        wb_dbus_we_i,
    input  logic [3:0]  wb_dbus_sel_i,
    input  logic        wb_dbus_stb_i,
    input  logic        wb_dbus_cyc_i,
    output logic [31:0] wb_dbus_dat_o,
    output logic        wb_dbus_ack_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        timeout_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_grant_q;
    logic       last_grant_d;
    logic       expire_s;
    logic       timeout_s;
    logic       ibus_req_s;
    logic       dbus_req_s;

    assign ibus_req_s = wb_ibus_cyc_i;
    assign dbus_req_s = wb_dbus_cyc_i & wb_dbus_stb_i;
    assign timeout_o  = timeout_s;

    wb_timeout_ctr #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .clr_i    (state_q == ST_IDLE),
        .en_i     ((state_q != ST_IDLE) && !wb_ack_i),
        .expire_o (expire_s)
    );

    // Forced termination only while the granted master still holds its cycle;
    // a real slave ack in the same cycle takes precedence.
    always_comb begin
        timeout_s = 1'b0;
        case (state_q)
            ST_GNT_I: timeout_s = expire_s & ~wb_ack_i & wb_ibus_cyc_i;
            ST_GNT_D: timeout_s = expire_s & ~wb_ack_i & wb_dbus_cyc_i;
            default:  timeout_s = 1'b0;
        endcase
    end

    // Next grant and round-robin bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                state_d = rr_pick(ibus_req_s, dbus_req_s, last_grant_q);
                if (state_d == ST_GNT_I) begin
                    last_grant_d = GRANT_I;
                end else if (state_d == ST_GNT_D) begin
                    last_grant_d = GRANT_D;
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            ST_GNT_I: begin
                if (wb_ack_i || timeout_s || !wb_ibus_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GNT_I;
                end
            end
            ST_GNT_D: begin
                if (wb_ack_i || timeout_s || !wb_dbus_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GNT_D;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter FSM state and last-grant register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Slave-port mux and ack/data return; everything decodes from the
    // registered state so reset clears the bus without a clock edge.
    always_comb begin
        wb_adr_o      = 32'h0000_0000;
        wb_dat_o      = 32'h0000_0000;
        wb_we_o       = 1'b0;
        wb_sel_o      = 4'h0;
        wb_stb_o      = 1'b0;
        wb_cyc_o      = 1'b0;
        wb_ibus_ack_o = 1'b0;
        wb_dbus_ack_o = 1'b0;
        wb_ibus_dat_o = wb_dat_i;
        wb_dbus_dat_o = wb_dat_i;
        case (state_q)
            ST_GNT_I: begin
                wb_adr_o      = wb_ibus_adr_i;
                wb_sel_o      = 4'hF;
                wb_stb_o      = wb_ibus_cyc_i & ~timeout_s;
                wb_cyc_o      = wb_ibus_cyc_i & ~timeout_s;
                wb_ibus_ack_o = wb_ack_i | timeout_s;
                if (timeout_s) begin
                    wb_ibus_dat_o = TIMEOUT_DATA;
                end else begin
                    wb_ibus_dat_o = wb_dat_i;
                end
            end
            ST_GNT_D: begin
                wb_adr_o      = wb_dbus_adr_i;
                wb_dat_o      = wb_dbus_dat_i;
                wb_we_o       = wb_dbus_we_i;
                wb_sel_o      = wb_dbus_sel_i;
                wb_stb_o      = wb_dbus_stb_i & ~timeout_s;
                wb_cyc_o      = wb_dbus_cyc_i & ~timeout_s;
                wb_dbus_ack_o = wb_ack_i | timeout_s;
                if (timeout_s) begin
                    wb_dbus_dat_o = TIMEOUT_DATA;
                end else begin
                    wb_dbus_dat_o = wb_dat_i;
                end
            end
            default: begin
                wb_cyc_o = 1'b0;
            end
        endcase
    end

endmodule
